// File: rtl/alu_result_collector_if.sv
// Bundle of signals between alu_4bit, the result collector and its consumer.
// The master modport is the collector's view; the slave modport is the environment's view.
interface alu_result_collector_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             issue_valid;
  logic [2:0]       opcode;
  logic [3:0]       out_not_reg;
  logic [3:0]       out_and_reg;
  logic [3:0]       out_xor_reg;
  logic [3:0]       sum_out_reg;
  logic             carry_out_reg;
  logic             m_valid;
  logic             m_ready;
  logic [2:0]       m_opcode;
  logic [3:0]       m_result;
  logic             m_carry;
  logic             m_zero;
  logic [CW-1:0]    fifo_count;
  logic             err_opcode;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    input  issue_valid, opcode, out_not_reg, out_and_reg, out_xor_reg,
           sum_out_reg, carry_out_reg, m_ready,
    output m_valid, m_opcode, m_result, m_carry, m_zero, fifo_count,
           err_opcode, drop_cnt
  );

  modport slave (
    output issue_valid, opcode, out_not_reg, out_and_reg, out_xor_reg,
           sum_out_reg, carry_out_reg, m_ready,
    input  m_valid, m_opcode, m_result, m_carry, m_zero, fifo_count,
           err_opcode, drop_cnt
  );
endinterface

// File: rtl/alu_result_collector.sv
// Aligns issued opcodes with alu_4bit registered outputs, selects the produced result,
// tags it with carry/zero flags and queues it in a small FIFO drained by valid/ready.
module alu_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  alu_result_collector_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0] opcode;
    logic [3:0] result;
    logic       carry;
    logic       zero;
  } entry_t;

  entry_t           mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             v_d_reg;
  logic [2:0]       op_d_reg;
  logic             err_reg;
  logic [CNT_W-1:0] drop_reg;

  entry_t           sel_entry;
  logic             sel_valid;
  logic             full, empty, push, pop, drop;
  logic [AW-1:0]    head_idx;

  // Result select for the op issued one cycle ago
  always_comb begin
    sel_entry = '0;
    sel_entry.opcode = op_d_reg;
    case (op_d_reg)
      3'd0: sel_entry.result = bus.out_not_reg;
      3'd1: sel_entry.result = bus.out_and_reg;
      3'd2: sel_entry.result = bus.out_xor_reg;
      3'd3: begin
        sel_entry.result = bus.sum_out_reg;
        sel_entry.carry  = bus.carry_out_reg;
      end
      default: sel_entry.result = 4'h0;
    endcase
    sel_entry.zero = (sel_entry.result == 4'h0);
  end

  assign sel_valid = v_d_reg & ~op_d_reg[2];
  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign pop       = ~empty & bus.m_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push      = sel_valid & (~full | pop);
  assign drop      = sel_valid & full & ~pop;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_d_reg    <= 1'b0;
      op_d_reg   <= 3'd0;
      err_reg    <= 1'b0;
      drop_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      v_d_reg   <= bus.issue_valid;
      op_d_reg  <= bus.opcode;
      err_reg   <= v_d_reg & op_d_reg[2];
      count_reg <= count_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (drop && drop_reg != '1)
        drop_reg <= drop_reg + CNT_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          mem_reg[gi] <= '0;
        else if (push && wr_ptr_reg == AW'(gi))
          mem_reg[gi] <= sel_entry;
      end
    end
  endgenerate

  // When empty, point at the most recently popped slot so m_* hold their last value
  assign head_idx = empty ? (rd_ptr_reg - AW'(1)) : rd_ptr_reg;

  assign bus.m_valid    = ~empty;
  assign bus.m_opcode   = mem_reg[head_idx].opcode;
  assign bus.m_result   = mem_reg[head_idx].result;
  assign bus.m_carry    = mem_reg[head_idx].carry;
  assign bus.m_zero     = mem_reg[head_idx].zero;
  assign bus.fifo_count = count_reg;
  assign bus.err_opcode = err_reg;
  assign bus.drop_cnt   = drop_reg;
endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector; a small registered ALU stands in for alu_4bit.
module tb_alu_result_collector;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a = 4'h0, b = 4'h0;
  logic       cin = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  alu_result_collector_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus_if ();

  alu_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Stand-in for alu_4bit: one register stage from operands to outputs
  always_ff @(posedge clk) begin
    bus_if.out_not_reg <= ~a;
    bus_if.out_and_reg <= a & b;
    bus_if.out_xor_reg <= a ^ b;
    {bus_if.carry_out_reg, bus_if.sum_out_reg} <= {1'b0, a} + {1'b0, b} + {4'b0, cin};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] aa, input logic [3:0] bb,
                       input logic cc);
    bus_if.issue_valid = 1'b1;
    bus_if.opcode      = op;
    a   = aa;
    b   = bb;
    cin = cc;
    $display("issue op=%0d a=%0h b=%0h c_in=%0b", op, aa, bb, cc);
    tick();
    bus_if.issue_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus_if.m_ready = 1'b1;
    tick();
    bus_if.m_ready = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    bus_if.issue_valid = 1'b0;
    bus_if.opcode      = 3'd0;
    bus_if.m_ready     = 1'b0;
    tick();
    tick();
    chk("rst_m_valid", 32'(bus_if.m_valid), 0);
    chk("rst_count", 32'(bus_if.fifo_count), 0);
    chk("rst_drop", 32'(bus_if.drop_cnt), 0);
    chk("rst_err", 32'(bus_if.err_opcode), 0);
    chk("rst_result", 32'(bus_if.m_result), 0);
    rst = 1'b0;
    tick();

    // ADD 5+2: m_valid two cycles after issue, not one
    issue(3'd3, 4'h5, 4'h2, 1'b0);
    chk("add_no_bypass", 32'(bus_if.m_valid), 0);
    tick();
    chk("add_m_valid", 32'(bus_if.m_valid), 1);
    chk("add_result", 32'(bus_if.m_result), 32'h7);
    chk("add_carry", 32'(bus_if.m_carry), 0);
    chk("add_zero", 32'(bus_if.m_zero), 0);
    chk("add_opcode", 32'(bus_if.m_opcode), 3);
    chk("add_count", 32'(bus_if.fifo_count), 1);
    pop_one();
    $display("pop result=7");
    chk("pop_empty", 32'(bus_if.m_valid), 0);
    chk("pop_count", 32'(bus_if.fifo_count), 0);
    chk("hold_result", 32'(bus_if.m_result), 32'h7);

    // ADD F+1 wraps to zero with carry
    issue(3'd3, 4'hF, 4'h1, 1'b0);
    tick();
    chk("addf_result", 32'(bus_if.m_result), 32'h0);
    chk("addf_carry", 32'(bus_if.m_carry), 1);
    chk("addf_zero", 32'(bus_if.m_zero), 1);
    pop_one();
    issue(3'd0, 4'h5, 4'h0, 1'b0);
    tick();
    chk("not_result", 32'(bus_if.m_result), 32'hA);
    chk("not_carry", 32'(bus_if.m_carry), 0);
    chk("not_opcode", 32'(bus_if.m_opcode), 0);
    pop_one();

    // Six back-to-back issues into a 4-deep FIFO with the consumer stalled
    issue(3'd3, 4'h5, 4'h2, 1'b0);  // 7
    issue(3'd1, 4'hC, 4'hA, 1'b0);  // 8
    issue(3'd2, 4'hC, 4'hA, 1'b0);  // 6
    issue(3'd0, 4'h3, 4'h0, 1'b0);  // C
    issue(3'd3, 4'h9, 4'h9, 1'b0);  // 2, dropped
    issue(3'd1, 4'hF, 4'hF, 1'b0);  // F, dropped
    tick();
    tick();
    chk("full_count", 32'(bus_if.fifo_count), 4);
    chk("full_drop", 32'(bus_if.drop_cnt), 2);
    bus_if.m_ready = 1'b1;
    chk("drain0_result", 32'(bus_if.m_result), 32'h7);
    chk("drain0_opcode", 32'(bus_if.m_opcode), 3);
    tick();
    chk("drain1_result", 32'(bus_if.m_result), 32'h8);
    chk("drain1_opcode", 32'(bus_if.m_opcode), 1);
    tick();
    chk("drain2_result", 32'(bus_if.m_result), 32'h6);
    chk("drain2_opcode", 32'(bus_if.m_opcode), 2);
    tick();
    chk("drain3_result", 32'(bus_if.m_result), 32'hC);
    chk("drain3_opcode", 32'(bus_if.m_opcode), 0);
    chk("drain3_valid", 32'(bus_if.m_valid), 1);
    tick();
    bus_if.m_ready = 1'b0;
    $display("drained 4 entries");
    chk("drain_empty", 32'(bus_if.m_valid), 0);
    chk("drain_count", 32'(bus_if.fifo_count), 0);

    // Refill, then push and pop in the same cycle while full
    issue(3'd3, 4'h0, 4'h1, 1'b0);  // 1
    issue(3'd3, 4'h1, 4'h1, 1'b0);  // 2
    issue(3'd3, 4'h1, 4'h2, 1'b0);  // 3
    issue(3'd3, 4'h2, 4'h2, 1'b0);  // 4
    tick();
    chk("refill_count", 32'(bus_if.fifo_count), 4);
    issue(3'd0, 4'h0, 4'h0, 1'b0);  // F, pushed as head pops
    bus_if.m_ready = 1'b1;
    tick();
    bus_if.m_ready = 1'b0;
    chk("pushpop_count", 32'(bus_if.fifo_count), 4);
    chk("pushpop_drop", 32'(bus_if.drop_cnt), 2);
    chk("pushpop_head", 32'(bus_if.m_result), 32'h2);

    // Drop counter growth and saturation
    bus_if.issue_valid = 1'b1;
    bus_if.opcode      = 3'd0;
    for (int i = 0; i < 10; i++) tick();
    bus_if.issue_valid = 1'b0;
    tick();
    $display("10 drops issued");
    chk("drop_12", 32'(bus_if.drop_cnt), 12);
    bus_if.issue_valid = 1'b1;
    for (int i = 0; i < 242; i++) tick();
    bus_if.issue_valid = 1'b0;
    tick();
    $display("242 drops issued");
    chk("drop_fe", 32'(bus_if.drop_cnt), 32'hFE);
    bus_if.issue_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus_if.issue_valid = 1'b0;
    tick();
    $display("5 drops issued");
    chk("drop_sat", 32'(bus_if.drop_cnt), 32'hFF);

    // Asynchronous reset with the FIFO full
    rst = 1'b1;
    #1;
    $display("async reset asserted");
    chk("arst_valid", 32'(bus_if.m_valid), 0);
    chk("arst_count", 32'(bus_if.fifo_count), 0);
    chk("arst_drop", 32'(bus_if.drop_cnt), 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_valid", 32'(bus_if.m_valid), 0);

    // Reserved opcode pulses err_opcode once, queues nothing
    issue(3'd5, 4'h3, 4'h3, 1'b0);
    chk("err_early", 32'(bus_if.err_opcode), 0);
    tick();
    chk("err_pulse", 32'(bus_if.err_opcode), 1);
    chk("err_count", 32'(bus_if.fifo_count), 0);
    chk("err_valid", 32'(bus_if.m_valid), 0);
    tick();
    chk("err_end", 32'(bus_if.err_opcode), 0);
    bus_if.opcode = 3'd6;
    $display("idle cycles with opcode=6");
    tick();
    tick();
    chk("idle_err", 32'(bus_if.err_opcode), 0);
    bus_if.opcode = 3'd1;
    tick();
    tick();
    chk("idle_count", 32'(bus_if.fifo_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
